// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory path: dmem geometry and requester port indices.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 12;
  localparam int unsigned DMEM_DATA_W = 32;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_LDR = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on contention the port that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       sel
);

  always_comb begin
    gnt = 2'b00;
    sel = 1'b0;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: begin
        gnt = 2'b10;
        sel = 1'b1;
      end
      2'b11: begin
        if (last) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
          sel = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported dmem between the processor data port and the loader/debug port,
// returning read data to whichever port issued the read and counting contention cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [CNT_W-1:0]  conflicts
);

  logic [1:0]       req_v;
  logic [1:0]       gnt;
  logic             sel;
  logic             last_q, last_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic [CNT_W-1:0] conflicts_q, conflicts_d;

  // Requests are masked while reset is low so nothing reaches dmem during reset.
  assign req_v = {req1 & reset, req0 & reset};

  rr_arb2 u_rr_arb2 (
    .req  (req_v),
    .last (last_q),
    .gnt  (gnt),
    .sel  (sel)
  );

  assign gnt0 = gnt[PORT_CPU];
  assign gnt1 = gnt[PORT_LDR];

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    unique case (gnt)
      2'b01: begin
        mem_address = addr0;
        mem_data    = wdata0;
        mem_wren    = we0;
      end
      2'b10: begin
        mem_address = addr1;
        mem_data    = wdata1;
        mem_wren    = we1;
      end
      default: ;
    endcase
  end

  always_comb begin
    last_d      = (|gnt) ? sel : last_q;
    rvalid0_d   = gnt[PORT_CPU] & ~we0;
    rvalid1_d   = gnt[PORT_LDR] & ~we1;
    conflicts_d = conflicts_q;
    if (req0 && req1 && (conflicts_q != {CNT_W{1'b1}})) begin
      conflicts_d = conflicts_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q      <= 1'b1;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      conflicts_q <= '0;
    end else begin
      last_q      <= last_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = mem_q;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned CntW = 4;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b1, we0 = 1'b0, req1 = 1'b1, we1 = 1'b0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_wren;
  logic [31:0] rdata, mem_data;
  logic [31:0] mem_q = '0;
  logic [11:0] mem_address;
  logic [CntW-1:0] conflicts;

  dmem_arbiter #(
    .ADDR_W (12),
    .DATA_W (32),
    .CNT_W  (CntW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0),
    .we0         (we0),
    .addr0       (addr0),
    .wdata0      (wdata0),
    .req1        (req1),
    .we1         (we1),
    .addr1       (addr1),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rvalid0     (rvalid0),
    .rvalid1     (rvalid1),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .conflicts   (conflicts)
  );

  always #5 clock = ~clock;

  // Behavioural syncram standing in for the dmem instance.
  logic [31:0] dmem [4096];
  initial for (int i = 0; i < 4096; i++) dmem[i] = '0;
  always @(posedge clock) begin
    if (mem_wren) dmem[mem_address] <= mem_data;
    mem_q <= dmem[mem_address];
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state, expressed in terms of transactions rather than RTL registers.
  int          m_last;
  int          m_conf;
  bit          m_rv0, m_rv1;
  bit [31:0]   m_rdata;
  bit [31:0]   ref_mem [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_conf  = 0;
    m_rv0   = 1'b0;
    m_rv1   = 1'b0;
    m_rdata = '0;
  endtask

  // One clock cycle: drive the requests, check every output, advance the model at the edge.
  task automatic step(input bit r0, input bit w0, input bit [11:0] a0, input bit [31:0] d0,
                      input bit r1, input bit w1, input bit [11:0] a1, input bit [31:0] d1,
                      output bit g0, output bit g1);
    int        win;
    bit        ww;
    bit [11:0] wa;
    bit [31:0] wd;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    if (r0 && r1) win = (m_last == 0) ? 1 : 0;
    else if (r0)  win = 0;
    else if (r1)  win = 1;
    else          win = -1;
    g0 = (win == 0);
    g1 = (win == 1);
    ww = (win == 0) ? w0 : (win == 1) ? w1 : 1'b0;
    wa = (win == 0) ? a0 : (win == 1) ? a1 : 12'h0;
    wd = (win == 0) ? d0 : (win == 1) ? d1 : 32'h0;
    check("gnt0", gnt0, g0);
    check("gnt1", gnt1, g1);
    check("mem_wren", mem_wren, ww);
    check("mem_address", mem_address, wa);
    check("mem_data", mem_data, wd);
    check("rvalid0", rvalid0, m_rv0);
    check("rvalid1", rvalid1, m_rv1);
    if (m_rv0 || m_rv1) check("rdata", rdata, m_rdata);
    check("conflicts", conflicts, m_conf);
    @(posedge clock);
    if (win >= 0) m_last = win;
    if (r0 && r1 && m_conf < CntMax) m_conf++;
    m_rv0 = (win == 0) && !ww;
    m_rv1 = (win == 1) && !ww;
    if (win >= 0 && !ww) m_rdata = ref_mem.exists(int'(wa)) ? ref_mem[int'(wa)] : 32'h0;
    if (ww) ref_mem[int'(wa)] = wd;
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit g0, g1;
    bit        p_r [2];
    bit        p_w [2];
    bit [11:0] p_a [2];
    bit [31:0] p_d [2];

    // Reset held with both ports requesting: nothing may be granted or written.
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_wren", mem_wren, 1'b0);
    check("rst_addr", mem_address, 12'h0);
    check("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
    check("rst_conf", conflicts, 4'h0);
    reset = 1'b1;

    step(1, 0, 12'h001, 0, 1, 0, 12'h002, 0, g0, g1);
    check("first_conf", conflicts, 4'h1);

    // Port 0 write then read back.
    step(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 0, 0, g0, g1);
    step(1, 0, 12'h010, 0, 0, 0, 0, 0, g0, g1);
    check("rd_rvalid0", rvalid0, 1'b1);
    check("rd_rdata", rdata, 32'hDEADBEEF);
    check("rd_rvalid1", rvalid1, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    // Port 1 alone writes the top address, then reads it back.
    step(0, 0, 0, 0, 1, 1, 12'hFFF, 32'h1, g0, g1);
    step(0, 0, 0, 0, 1, 0, 12'hFFF, 0, g0, g1);
    check("ldr_rvalid1", rvalid1, 1'b1);
    check("ldr_rdata", rdata, 32'h1);

    // Continuous contention: strictly alternating grants starting with port 0.
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 12'h010, 0, 1, 0, 12'hFFF, 0, g0, g1);
      check("alt_gnt0", g0, (i % 2) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    check("alt_conf", conflicts, 4'h7);

    // Reset pulse in the middle of a cycle holding a granted read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010; req1 = 1'b0;
    #1;
    check("pulse_gnt0", gnt0, 1'b1);
    #1;
    reset = 1'b0;
    req0  = 1'b0;
    #1;
    check("pulse_gnt0_low", gnt0, 1'b0);
    check("pulse_conf", conflicts, 4'h0);
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    check("pulse_rvalid0", rvalid0, 1'b0);
    step(1, 0, 12'h003, 0, 1, 0, 12'h004, 0, g0, g1);
    check("pulse_last", g0, 1'b1);

    // Saturation of the contention counter.
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 12'($urandom_range(0, 31)), 0, 1, 0, 12'($urandom_range(0, 31)), 0, g0, g1);
    end
    check("sat_conf", conflicts, 4'hF);

    // Randomised traffic with requesters holding requests until granted.
    for (int p = 0; p < 2; p++) p_r[p] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_r[p]) begin
          p_r[p] = ($urandom_range(0, 3) != 0);
          p_w[p] = $urandom_range(0, 1) == 1;
          p_a[p] = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 31));
          p_d[p] = $urandom;
        end
      end
      step(p_r[0], p_w[0], p_a[0], p_d[0], p_r[1], p_w[1], p_a[1], p_d[1], g0, g1);
      if (g0) p_r[0] = 1'b0;
      if (g1) p_r[1] = 1'b0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
